// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the 5-stage IF/ID/EX/MEM/WB core.
//
// Ports
//   clk_i, rst_i              : core clock, asynchronous active-high reset
//   id_*                      : ID-stage instruction info (valid, rs1/rs2, uses)
//   ex_*                      : ID/EX register info (valid, load, rd, redirect)
//   mem_*                     : EX/MEM register info (valid, busy, exception,
//                               fence.i, instruction PC)
//   trap_vec_i                : trap handler target (mtvec)
//   icache_flush_valid_o/
//   icache_flush_ready_i      : fence.i instruction-cache flush handshake
//   stall_{if,id,ex,mem}_o    : hold the corresponding stage register
//   flush_{id,ex,mem,wb}_o    : load a bubble into IF/ID, ID/EX, EX/MEM, MEM/WB
//   redirect_valid_o/_pc_o    : load fetch PC at the next clock edge
//   trap_commit_o             : pulse telling the CSR file to latch trap info
//   stall_cycles_o            : saturating count of cycles with stall_if_o=1
//
// All control outputs are combinational from the FSM state and the inputs,
// so redirects and stalls take effect at the very next clock edge.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int Xlen = 32,
    parameter int CntW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic            id_uses_rs1_i,
    input  logic            id_uses_rs2_i,
    input  logic            ex_valid_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic            ex_redirect_i,
    input  logic [Xlen-1:0] ex_target_i,
    input  logic            mem_valid_i,
    input  logic            mem_busy_i,
    input  logic            mem_expt_valid_i,
    input  logic            mem_is_fencei_i,
    input  logic [Xlen-1:0] mem_pc_i,
    input  logic [Xlen-1:0] trap_vec_i,
    output logic            icache_flush_valid_o,
    input  logic            icache_flush_ready_i,
    output logic            stall_if_o,
    output logic            stall_id_o,
    output logic            stall_ex_o,
    output logic            stall_mem_o,
    output logic            flush_id_o,
    output logic            flush_ex_o,
    output logic            flush_mem_o,
    output logic            flush_wb_o,
    output logic            redirect_valid_o,
    output logic [Xlen-1:0] redirect_pc_o,
    output logic            trap_commit_o,
    output logic [CntW-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

    state_t          r_state;
    logic [Xlen-1:0] r_fencei_pc;
    logic [CntW-1:0] r_stall_cnt;

    logic w_mem_hold;
    logic w_trap;
    logic w_fencei;
    logic w_ex_redirect;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_enter_flush;

    // Raw event detection; priority is resolved in the output decoder.
    assign w_mem_hold    = mem_valid_i & mem_busy_i;
    assign w_trap        = mem_valid_i & mem_expt_valid_i;
    assign w_fencei      = mem_valid_i & mem_is_fencei_i;
    assign w_ex_redirect = ex_valid_i & ex_redirect_i;
    assign w_rs1_hit     = id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i);
    assign w_rs2_hit     = id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i);
    // x0 is never a real producer, so a load into x0 cannot create a hazard.
    assign w_load_use    = ex_valid_i & ex_is_load_i & (ex_rd_addr_i != 5'd0) &
                           id_valid_i & (w_rs1_hit | w_rs2_hit);
    assign w_enter_flush = (r_state == ST_RUN) & ~w_mem_hold & ~w_trap & w_fencei;

    assign stall_cycles_o = r_stall_cnt;

    always_comb begin
        icache_flush_valid_o = 1'b0;
        stall_if_o           = 1'b0;
        stall_id_o           = 1'b0;
        stall_ex_o           = 1'b0;
        stall_mem_o          = 1'b0;
        flush_id_o           = 1'b0;
        flush_ex_o           = 1'b0;
        flush_mem_o          = 1'b0;
        flush_wb_o           = 1'b0;
        redirect_valid_o     = 1'b0;
        redirect_pc_o        = '0;
        trap_commit_o        = 1'b0;

        if (rst_i) begin
            // Keep bubbles in every stage while reset is held; this also
            // drops an in-flight flush request without waiting for a clock.
            flush_id_o  = 1'b1;
            flush_ex_o  = 1'b1;
            flush_mem_o = 1'b1;
            flush_wb_o  = 1'b1;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_mem_hold) begin
                        // Freeze everything up to MEM; a pending EX redirect
                        // simply stays in ID/EX and is acted on later.
                        stall_if_o  = 1'b1;
                        stall_id_o  = 1'b1;
                        stall_ex_o  = 1'b1;
                        stall_mem_o = 1'b1;
                        flush_wb_o  = 1'b1;
                    end else if (w_trap) begin
                        // Trapping instruction still moves to WB (with its
                        // exception flag) so WB can suppress the write.
                        flush_id_o       = 1'b1;
                        flush_ex_o       = 1'b1;
                        flush_mem_o      = 1'b1;
                        redirect_valid_o = 1'b1;
                        redirect_pc_o    = trap_vec_i;
                        trap_commit_o    = 1'b1;
                    end else if (w_fencei) begin
                        stall_if_o  = 1'b1;
                        flush_id_o  = 1'b1;
                        flush_ex_o  = 1'b1;
                        flush_mem_o = 1'b1;
                    end else if (w_ex_redirect) begin
                        flush_id_o       = 1'b1;
                        flush_ex_o       = 1'b1;
                        redirect_valid_o = 1'b1;
                        redirect_pc_o    = ex_target_i;
                    end else if (w_load_use) begin
                        // The bubble in ID/EX lets the load reach MEM, so the
                        // hazard clears after exactly one cycle.
                        stall_if_o = 1'b1;
                        stall_id_o = 1'b1;
                        flush_ex_o = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    icache_flush_valid_o = 1'b1;
                    stall_if_o           = 1'b1;
                    flush_id_o           = 1'b1;
                    flush_ex_o           = 1'b1;
                    flush_mem_o          = 1'b1;
                end
                ST_REFILL: begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = r_fencei_pc + {{(Xlen-3){1'b0}}, 3'd4};
                    flush_id_o       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
        end else begin
            if (stall_if_o && (r_stall_cnt != {CntW{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            unique case (r_state)
                ST_RUN: begin
                    if (w_enter_flush) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (icache_flush_ready_i) begin
                        r_state <= ST_REFILL;
                    end
                end
                ST_REFILL: r_state <= ST_RUN;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

    // PC of the fence.i, captured when the flush sequence starts.
    always_ff @(posedge clk_i) begin
        if (w_enter_flush && !rst_i) begin
            r_fencei_pc <= mem_pc_i;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int XL = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          id_valid_i, id_uses_rs1_i, id_uses_rs2_i;
    logic [4:0]    id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic          ex_valid_i, ex_is_load_i, ex_redirect_i;
    logic [XL-1:0] ex_target_i, mem_pc_i, trap_vec_i;
    logic          mem_valid_i, mem_busy_i, mem_expt_valid_i, mem_is_fencei_i;
    logic          icache_flush_valid_o, icache_flush_ready_i;
    logic          stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
    logic          flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o;
    logic          redirect_valid_o, trap_commit_o;
    logic [XL-1:0] redirect_pc_o;
    logic [CW-1:0] stall_cycles_o;

    pipeline_ctrl #(.Xlen(XL), .CntW(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i),
        .id_rs2_addr_i(id_rs2_addr_i), .id_uses_rs1_i(id_uses_rs1_i),
        .id_uses_rs2_i(id_uses_rs2_i),
        .ex_valid_i(ex_valid_i), .ex_is_load_i(ex_is_load_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_redirect_i(ex_redirect_i),
        .ex_target_i(ex_target_i),
        .mem_valid_i(mem_valid_i), .mem_busy_i(mem_busy_i),
        .mem_expt_valid_i(mem_expt_valid_i), .mem_is_fencei_i(mem_is_fencei_i),
        .mem_pc_i(mem_pc_i), .trap_vec_i(trap_vec_i),
        .icache_flush_valid_o(icache_flush_valid_o),
        .icache_flush_ready_i(icache_flush_ready_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
        .stall_ex_o(stall_ex_o), .stall_mem_o(stall_mem_o),
        .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
        .flush_mem_o(flush_mem_o), .flush_wb_o(flush_wb_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .trap_commit_o(trap_commit_o), .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: sequencing mode, captured fence.i PC, stall count.
    typedef enum int {M_RUN, M_FLUSH, M_REFILL} mode_t;
    typedef enum int {A_NONE, A_HOLD, A_TRAP, A_FENCE, A_BRANCH, A_LOADUSE} act_t;
    mode_t         m_mode;
    logic [XL-1:0] m_pc;
    int            m_cnt;

    // Expected outputs for the current cycle.
    logic          e_icv, e_sif, e_sid, e_sex, e_smem;
    logic          e_fid, e_fex, e_fmem, e_fwb, e_rv, e_tc;
    logic [XL-1:0] e_rpc;
    act_t          e_act;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit reads_reg(input logic [4:0] r);
        return (id_uses_rs1_i && id_rs1_addr_i == r) || (id_uses_rs2_i && id_rs2_addr_i == r);
    endfunction

    task automatic compute_exp();
        {e_icv, e_sif, e_sid, e_sex, e_smem} = '0;
        {e_fid, e_fex, e_fmem, e_fwb, e_rv, e_tc} = '0;
        e_rpc = '0;
        e_act = A_NONE;
        if (rst_i) begin
            {e_fid, e_fex, e_fmem, e_fwb} = 4'hF;
        end else if (m_mode == M_FLUSH) begin
            e_icv = 1; e_sif = 1; e_fid = 1; e_fex = 1; e_fmem = 1;
        end else if (m_mode == M_REFILL) begin
            e_rv = 1; e_rpc = m_pc + 32'd4; e_fid = 1;
        end else begin
            if (mem_valid_i && mem_busy_i) e_act = A_HOLD;
            else if (mem_valid_i && mem_expt_valid_i) e_act = A_TRAP;
            else if (mem_valid_i && mem_is_fencei_i) e_act = A_FENCE;
            else if (ex_valid_i && ex_redirect_i) e_act = A_BRANCH;
            else if (ex_valid_i && ex_is_load_i && ex_rd_addr_i != 0 && id_valid_i &&
                     reads_reg(ex_rd_addr_i)) e_act = A_LOADUSE;
            case (e_act)
                A_HOLD:    begin e_sif = 1; e_sid = 1; e_sex = 1; e_smem = 1; e_fwb = 1; end
                A_TRAP:    begin e_fid = 1; e_fex = 1; e_fmem = 1; e_rv = 1; e_rpc = trap_vec_i; e_tc = 1; end
                A_FENCE:   begin e_sif = 1; e_fid = 1; e_fex = 1; e_fmem = 1; end
                A_BRANCH:  begin e_fid = 1; e_fex = 1; e_rv = 1; e_rpc = ex_target_i; end
                A_LOADUSE: begin e_sif = 1; e_sid = 1; e_fex = 1; end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string p);
        check({p, "_icv"},   64'(icache_flush_valid_o), 64'(e_icv));
        check({p, "_sif"},   64'(stall_if_o),  64'(e_sif));
        check({p, "_sid"},   64'(stall_id_o),  64'(e_sid));
        check({p, "_sex"},   64'(stall_ex_o),  64'(e_sex));
        check({p, "_smem"},  64'(stall_mem_o), 64'(e_smem));
        check({p, "_fid"},   64'(flush_id_o),  64'(e_fid));
        check({p, "_fex"},   64'(flush_ex_o),  64'(e_fex));
        check({p, "_fmem"},  64'(flush_mem_o), 64'(e_fmem));
        check({p, "_fwb"},   64'(flush_wb_o),  64'(e_fwb));
        check({p, "_rv"},    64'(redirect_valid_o), 64'(e_rv));
        if (e_rv) check({p, "_rpc"}, 64'(redirect_pc_o), 64'(e_rpc));
        check({p, "_tc"},    64'(trap_commit_o), 64'(e_tc));
        check({p, "_cnt"},   64'(stall_cycles_o), 64'(m_cnt));
    endtask

    // One clock cycle: check current outputs, clock, advance the model.
    task automatic step(input string p);
        #2;
        compute_exp();
        compare_all(p);
        @(posedge clk_i);
        if (e_sif && m_cnt < CNT_MAX) m_cnt++;
        case (m_mode)
            M_RUN:    if (e_act == A_FENCE) begin m_mode = M_FLUSH; m_pc = mem_pc_i; end
            M_FLUSH:  if (icache_flush_ready_i) m_mode = M_REFILL;
            default:  m_mode = M_RUN;
        endcase
        #1;
    endtask

    task automatic idle_inputs();
        id_valid_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        id_uses_rs1_i = 0; id_uses_rs2_i = 0;
        ex_valid_i = 0; ex_is_load_i = 0; ex_rd_addr_i = 0;
        ex_redirect_i = 0; ex_target_i = 0;
        mem_valid_i = 0; mem_busy_i = 0; mem_expt_valid_i = 0;
        mem_is_fencei_i = 0; mem_pc_i = 0; trap_vec_i = 0;
        icache_flush_ready_i = 0;
    endtask

    int c0;
    int icv_cycles;

    initial begin
        idle_inputs();
        rst_i = 1;
        m_mode = M_RUN; m_pc = '0; m_cnt = 0;
        #3;
        compute_exp();
        compare_all("reset");
        #9 rst_i = 0;
        @(posedge clk_i); #1;

        // Load-use: ld x5 in EX, add x6,x5,x1 in ID.
        ex_valid_i = 1; ex_is_load_i = 1; ex_rd_addr_i = 5;
        id_valid_i = 1; id_rs1_addr_i = 5; id_rs2_addr_i = 1;
        id_uses_rs1_i = 1; id_uses_rs2_i = 1;
        #1 check("lu_stall_if", 64'(stall_if_o), 64'd1);
        check("lu_flush_ex", 64'(flush_ex_o), 64'd1);
        step("lu");
        ex_valid_i = 0; ex_is_load_i = 0;   // bubble now in EX
        #1 check("lu_after_stall", 64'(stall_if_o), 64'd0);
        step("lu_after");
        check("lu_cnt", 64'(stall_cycles_o), 64'd1);

        // No hazard: add x6,x0,x0 behind load x5; then load into x0.
        ex_valid_i = 1; ex_is_load_i = 1; ex_rd_addr_i = 5;
        id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        #1 check("nohz_x0src", 64'(stall_if_o), 64'd0);
        step("nohz_a");
        ex_rd_addr_i = 0;
        #1 check("nohz_rd0", 64'(stall_id_o), 64'd0);
        step("nohz_b");
        idle_inputs();

        // Taken branch to 0x100.
        ex_valid_i = 1; ex_redirect_i = 1; ex_target_i = 32'h100;
        #1 check("br_pc", 64'(redirect_pc_o), 64'h100);
        check("br_rv", 64'(redirect_valid_o), 64'd1);
        step("br");

        // Branch held behind 3 busy MEM cycles.
        c0 = m_cnt;
        mem_valid_i = 1; mem_busy_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("busy_norv", 64'(redirect_valid_o), 64'd0);
            step("busy");
        end
        mem_valid_i = 0; mem_busy_i = 0;
        #1 check("busy_release_pc", 64'(redirect_pc_o), 64'h100);
        check("busy_cnt", 64'(stall_cycles_o), 64'(c0 + 3));
        step("busy_release");
        idle_inputs();

        // fence.i at 0x80, ready low for 5 cycles.
        mem_valid_i = 1; mem_is_fencei_i = 1; mem_pc_i = 32'h80;
        step("fi_enter");
        idle_inputs();
        icv_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            icache_flush_ready_i = (i == 5);
            #1 if (icache_flush_valid_o === 1'b1) icv_cycles++;
            step("fi_flush");
        end
        check("fi_icv_cycles", 64'(icv_cycles), 64'd6);
        icache_flush_ready_i = 0;
        #1 check("fi_refill_pc", 64'(redirect_pc_o), 64'h84);
        check("fi_refill_icv", 64'(icache_flush_valid_o), 64'd0);
        step("fi_refill");
        step("fi_run");

        // fence.i at the top of the address space: PC+4 wraps to 0.
        mem_valid_i = 1; mem_is_fencei_i = 1; mem_pc_i = 32'hFFFF_FFFC;
        step("fiw_enter");
        idle_inputs();
        icache_flush_ready_i = 1;
        step("fiw_flush");
        icache_flush_ready_i = 0;
        #1 check("fiw_pc", 64'(redirect_pc_o), 64'h0);
        step("fiw_refill");

        // Trap in MEM with EX redirect pending.
        mem_valid_i = 1; mem_expt_valid_i = 1; trap_vec_i = 32'h200;
        ex_valid_i = 1; ex_redirect_i = 1; ex_target_i = 32'h100;
        #1 check("trap_pc", 64'(redirect_pc_o), 64'h200);
        check("trap_tc", 64'(trap_commit_o), 64'd1);
        step("trap");
        idle_inputs();
        #1 check("trap_tc_pulse", 64'(trap_commit_o), 64'd0);
        step("trap_after");

        // Saturation: long busy stall.
        mem_valid_i = 1; mem_busy_i = 1;
        for (int i = 0; i < 20; i++) step("sat");
        idle_inputs();
        #1 check("sat_cnt", 64'(stall_cycles_o), 64'(CNT_MAX));
        step("sat_after");

        // Reset asserted mid-FLUSH.
        mem_valid_i = 1; mem_is_fencei_i = 1; mem_pc_i = 32'h40;
        step("rst_enter");
        idle_inputs();
        step("rst_flush");
        #2 rst_i = 1;
        #1 check("rst_icv", 64'(icache_flush_valid_o), 64'd0);
        check("rst_cnt", 64'(stall_cycles_o), 64'd0);
        check("rst_flush_wb", 64'(flush_wb_o), 64'd1);
        check("rst_stall_if", 64'(stall_if_o), 64'd0);
        m_mode = M_RUN; m_cnt = 0;
        #2 rst_i = 0;
        @(posedge clk_i); #1;
        step("rst_after");

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            id_valid_i       = 1'($urandom_range(0, 1));
            id_rs1_addr_i    = 5'($urandom_range(0, 3));
            id_rs2_addr_i    = 5'($urandom_range(0, 3));
            id_uses_rs1_i    = 1'($urandom_range(0, 1));
            id_uses_rs2_i    = 1'($urandom_range(0, 1));
            ex_valid_i       = 1'($urandom_range(0, 1));
            ex_is_load_i     = 1'($urandom_range(0, 1));
            ex_rd_addr_i     = 5'($urandom_range(0, 3));
            ex_redirect_i    = ($urandom_range(0, 3) == 0);
            ex_target_i      = $urandom;
            mem_valid_i      = 1'($urandom_range(0, 1));
            mem_busy_i       = ($urandom_range(0, 3) == 0);
            mem_expt_valid_i = ($urandom_range(0, 5) == 0);
            mem_is_fencei_i  = ($urandom_range(0, 7) == 0);
            mem_pc_i         = $urandom;
            trap_vec_i       = $urandom;
            icache_flush_ready_i = 1'($urandom_range(0, 1));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
